// File: rtl/mem_multiport_model.sv
// ============================================================================
// Module      : mem_multiport_model
// Description : Multi-port word memory model with round-robin arbitration,
//               fixed service latency, byte-lane writes and per-port sticky
//               protocol-error flags. Optional random extra latency (0..3
//               cycles from an LFSR) when MEM_MULTIPORT_RAND_STALL_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_multiport_model #(
    parameter int          NUM_PORTS   = 2,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0][31:0]     addr,
    input  logic [NUM_PORTS-1:0][3:0]      rmask,
    input  logic [NUM_PORTS-1:0][3:0]      wmask,
    input  logic [NUM_PORTS-1:0][31:0]     wdata,
    output logic [NUM_PORTS-1:0][31:0]     rdata,
    output logic [NUM_PORTS-1:0]           resp,
    output logic [NUM_PORTS-1:0]           error
);

    localparam int          c_PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int          c_AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int          c_CW   = $clog2(LATENCY + 3) + 1;
    localparam logic [32:0] c_END  = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]                      r_state;
    logic [c_PW-1:0]                 r_ptr;
    logic [c_PW-1:0]                 r_gnt;
    logic [31:0]                     r_addr;
    logic [3:0]                      r_rmask;
    logic [3:0]                      r_wmask;
    logic [31:0]                     r_wdata;
    logic                            r_bad;
    logic [c_CW-1:0]                 r_cnt;
    logic [NUM_PORTS-1:0][31:0]      r_rdata;
    logic [NUM_PORTS-1:0]            r_error;
    logic [31:0]                     r_mem [DEPTH_WORDS];

    logic [NUM_PORTS-1:0]            w_req;
    logic                            w_any;
    logic [c_PW-1:0]                 w_pick;
    logic                            w_gnt_bad;
    logic [c_CW-1:0]                 w_load;
    logic                            w_changed;
    logic                            w_is_read;
    logic [c_AW-1:0]                 w_idx;
    logic [31:0]                     w_result;

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            assign w_req[p] = (|rmask[p]) | (|wmask[p]);
            assign resp[p]  = (r_state == c_RESP) && (r_gnt == c_PW'(p));
            // Read data is presented during the resp cycle and held afterwards.
            assign rdata[p] = (resp[p] && w_is_read) ? w_result : r_rdata[p];
        end
    endgenerate

    always_comb begin
        int idx;
        idx    = 0;
        w_any  = 1'b0;
        w_pick = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = (int'(r_ptr) + i) % NUM_PORTS;
            if (w_req[idx]) begin
                w_any  = 1'b1;
                w_pick = c_PW'(idx);
            end
        end
    end

    assign w_gnt_bad = (addr[w_pick][1:0] != 2'b00)
                    || ({1'b0, addr[w_pick]} <  {1'b0, BASE_ADDR})
                    || ({1'b0, addr[w_pick]} >= c_END)
                    || ((|rmask[w_pick]) && (|wmask[w_pick]));

    assign w_changed = (addr[r_gnt] != r_addr) || (rmask[r_gnt] != r_rmask)
                    || (wmask[r_gnt] != r_wmask);

    // BASE_ADDR is aligned to the array size, so the word index is a plain slice.
    assign w_idx     = r_addr[c_AW+1:2];
    assign w_is_read = r_bad || (r_rmask != 4'h0);
    assign w_result  = r_bad ? 32'h0 : r_mem[w_idx];

`ifdef MEM_MULTIPORT_RAND_STALL_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
        end
    end

    assign w_load = c_CW'(LATENCY - 1) + c_CW'(r_lfsr[1:0]);
`else
    assign w_load = c_CW'(LATENCY - 1);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_addr  <= '0;
            r_rmask <= '0;
            r_wmask <= '0;
            r_wdata <= '0;
            r_bad   <= 1'b0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_error <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_pick;
                        r_addr  <= addr[w_pick];
                        r_rmask <= rmask[w_pick];
                        r_wmask <= wmask[w_pick];
                        r_wdata <= wdata[w_pick];
                        r_bad   <= w_gnt_bad;
                        r_cnt   <= w_load;
                        if (w_gnt_bad) begin
                            r_error[w_pick] <= 1'b1;
                        end
                        r_state <= (w_load == '0) ? c_RESP : c_BUSY;
                    end
                end
                c_BUSY: begin
                    if (w_changed) begin
                        r_error[r_gnt] <= 1'b1;
                    end
                    r_cnt <= r_cnt - c_CW'(1);
                    if (r_cnt == c_CW'(1)) begin
                        r_state <= c_RESP;
                    end
                end
                c_RESP: begin
                    if (w_changed) begin
                        r_error[r_gnt] <= 1'b1;
                    end
                    if (w_is_read) begin
                        r_rdata[r_gnt] <= w_result;
                    end
                    r_ptr   <= (r_gnt == c_PW'(NUM_PORTS - 1)) ? '0 : r_gnt + c_PW'(1);
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign error = r_error;

    // Reset forces IDLE asynchronously, so an aborted transaction never writes.
    always_ff @(posedge clk) begin
        if ((r_state == c_RESP) && !r_bad) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wmask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_multiport_model.sv
// ============================================================================
// Module      : tb_mem_multiport_model
// Description : Directed self-checking bench for mem_multiport_model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_multiport_model;

    localparam int          c_LAT   = 4;
    localparam int          c_DEPTH = 1024;
    localparam logic [31:0] c_BASE  = 32'h0000_1000;

    logic              clk;
    logic              rst;
    logic [1:0][31:0]  addr;
    logic [1:0][3:0]   rmask;
    logic [1:0][3:0]   wmask;
    logic [1:0][31:0]  wdata;
    logic [1:0][31:0]  rdata;
    logic [1:0]        resp;
    logic [1:0]        error;

    int n_checks = 0;
    int n_fail   = 0;

    mem_multiport_model #(
        .NUM_PORTS   (2),
        .DEPTH_WORDS (c_DEPTH),
        .BASE_ADDR   (c_BASE),
        .LATENCY     (c_LAT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .rmask (rmask),
        .wmask (wmask),
        .wdata (wdata),
        .rdata (rdata),
        .resp  (resp),
        .error (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_lat(input string tag, input int lat);
`ifdef MEM_MULTIPORT_RAND_STALL_EN
        check(tag, 32'(lat >= c_LAT && lat <= c_LAT + 3), 32'd1);
`else
        check(tag, 32'(lat), 32'(c_LAT));
`endif
    endtask

    task automatic wait_resp(input int p, output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (resp[p]) begin
                lat = i;
                break;
            end
        end
    endtask

    // Issue one request, measure latency, then release the port the cycle after resp.
    task automatic do_txn(input int p, input logic [31:0] a, input logic [3:0] rm,
                          input logic [3:0] wm, input logic [31:0] wd, output int lat);
        addr[p]  = a;
        rmask[p] = rm;
        wmask[p] = wm;
        wdata[p] = wd;
        wait_resp(p, lat);
        @(posedge clk); #1;
        rmask[p] = 4'h0;
        wmask[p] = 4'h0;
    endtask

    initial begin
        int lat;
        int got_p [4];
        int got_c [4];
        logic [31:0] got_d [4];
        int n;
        int hist [4];

        rst   = 1'b0;
        addr  = '0;
        rmask = '0;
        wmask = '0;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp",   32'(resp),  32'h0);
        check("rst_error",  32'(error), 32'h0);
        check("rst_rdata0", rdata[0],   32'h0);
        check("rst_rdata1", rdata[1],   32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Full-word write then read on port 0
        do_txn(0, c_BASE + 32'h10, 4'h0, 4'hF, 32'hDEADBEEF, lat);
        chk_lat("wr_lat", lat);
        do_txn(0, c_BASE + 32'h10, 4'hF, 4'h0, 32'h0, lat);
        chk_lat("rd_lat", lat);
        check("rd_data", rdata[0], 32'hDEADBEEF);

        // Byte-lane write; the other port observes the merged word
        do_txn(0, c_BASE + 32'h10, 4'h0, 4'b0010, 32'h0000_5500, lat);
        do_txn(0, c_BASE + 32'h10, 4'hF, 4'h0, 32'h0, lat);
        check("lane_rd0", rdata[0], 32'hDEAD55EF);
        do_txn(1, c_BASE + 32'h10, 4'hF, 4'h0, 32'h0, lat);
        check("lane_rd1", rdata[1], 32'hDEAD55EF);
        check("rd0_hold", rdata[0], 32'hDEAD55EF);
        do_txn(1, c_BASE + 32'h20, 4'h0, 4'hF, 32'h12345678, lat);

        // Both ports request together and keep requesting
        for (int k = 0; k < 4; k++) begin
            got_p[k] = -1;
            got_c[k] = -100;
            got_d[k] = '0;
        end
        addr[0] = c_BASE + 32'h10; rmask[0] = 4'hF;
        addr[1] = c_BASE + 32'h20; rmask[1] = 4'hF;
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(posedge clk); #1;
            for (int q = 0; q < 2; q++) begin
                if (resp[q] && n < 4) begin
                    got_p[n] = q;
                    got_c[n] = i + 1;
                    got_d[n] = rdata[q];
                    n++;
                end
            end
        end
        @(posedge clk); #1;
        rmask = '0;
        check("arb_count", 32'(n), 32'd4);
        chk_lat("arb_first_lat", got_c[0]);
        for (int k = 0; k < 4; k++) begin
            check("arb_port", 32'(got_p[k]), 32'(k % 2));
            check("arb_data", got_d[k], (k % 2 == 0) ? 32'hDEAD55EF : 32'h12345678);
            if (k > 0) chk_lat("arb_spacing", got_c[k] - got_c[k-1] - 1);
        end

        // Protocol errors on port 1
        do_txn(1, c_BASE + 32'h20, 4'hF, 4'h0, 32'h0, lat);
        check("pre_err_rd", rdata[1], 32'h12345678);
        do_txn(1, c_BASE + 32'h2, 4'hF, 4'h0, 32'h0, lat);
        chk_lat("misal_lat", lat);
        check("misal_err1", 32'(error[1]), 32'd1);
        check("misal_rd",   rdata[1], 32'h0);
        check("misal_err0", 32'(error[0]), 32'd0);
        do_txn(1, c_BASE + 32'h12, 4'h0, 4'hF, 32'hFFFFFFFF, lat);
        chk_lat("misal_wr_lat", lat);
        do_txn(1, c_BASE + 32'h20, 4'hF, 4'h0, 32'h0, lat);
        check("err_sticky_rd", rdata[1], 32'h12345678);
        do_txn(1, c_BASE + 32'(c_DEPTH * 4), 4'hF, 4'h0, 32'h0, lat);
        chk_lat("oor_lat", lat);
        check("oor_rd",     rdata[1], 32'h0);
        check("oor_err1",   32'(error[1]), 32'd1);
        do_txn(0, c_BASE + 32'h10, 4'hF, 4'h0, 32'h0, lat);
        check("no_wr_on_err", rdata[0], 32'hDEAD55EF);
        check("err0_clean", 32'(error[0]), 32'd0);

        // Reset two cycles into BUSY, request dropped during reset
        do_txn(0, c_BASE + 32'h30, 4'h0, 4'hF, 32'h11111111, lat);
        do_txn(0, c_BASE + 32'h30, 4'hF, 4'h0, 32'h0, lat);
        addr[0] = c_BASE + 32'h30; wmask[0] = 4'hF; wdata[0] = 32'hAAAAAAAA;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_resp",  32'(resp),  32'h0);
        check("mid_rst_error", 32'(error), 32'h0);
        check("mid_rst_rdata", rdata[0],   32'h0);
        wmask[0] = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        do_txn(0, c_BASE + 32'h30, 4'hF, 4'h0, 32'h0, lat);
        check("rst_no_write", rdata[0], 32'h11111111);

        // Reset two cycles into BUSY, request held through reset
        addr[0] = c_BASE + 32'h30; wmask[0] = 4'hF; wdata[0] = 32'hAAAAAAAA;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        wait_resp(0, lat);
        chk_lat("regrant_lat", lat);
        @(posedge clk); #1;
        wmask[0] = 4'h0;
        do_txn(0, c_BASE + 32'h30, 4'hF, 4'h0, 32'h0, lat);
        check("regrant_wr", rdata[0], 32'hAAAAAAAA);

        // Address changed while BUSY: latched values used, error flagged
        do_txn(1, c_BASE + 32'h0, 4'h0, 4'hF, 32'hCAFEF00D, lat);
        do_txn(1, c_BASE + 32'h4, 4'h0, 4'hF, 32'h0BADC0DE, lat);
        check("pre_chg_err", 32'(error[1]), 32'd0);
        addr[1] = c_BASE; rmask[1] = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        addr[1] = c_BASE + 32'h4;
        wait_resp(1, lat);
        check("chg_resp",  32'(lat > 0), 32'd1);
        check("chg_rdata", rdata[1], 32'hCAFEF00D);
        check("chg_err1",  32'(error[1]), 32'd1);
        check("chg_err0",  32'(error[0]), 32'd0);
        @(posedge clk); #1;
        rmask[1] = 4'h0;

        // Both masks set on port 0
        do_txn(0, c_BASE + 32'h10, 4'hF, 4'hF, 32'h0, lat);
        chk_lat("both_lat", lat);
        check("both_err0", 32'(error[0]), 32'd1);
        check("both_rd",   rdata[0], 32'h0);
        do_txn(0, c_BASE + 32'h10, 4'hF, 4'h0, 32'h0, lat);
        check("both_no_wr", rdata[0], 32'hDEAD55EF);

`ifdef MEM_MULTIPORT_RAND_STALL_EN
        for (int k = 0; k < 4; k++) hist[k] = 0;
        for (int i = 0; i < 1000; i++) begin
            do_txn(i % 2, c_BASE + 32'h10, 4'hF, 4'h0, 32'h0, lat);
            chk_lat("stall_lat", lat);
            check("stall_data", rdata[i % 2], 32'hDEAD55EF);
            if (lat >= c_LAT && lat <= c_LAT + 3) hist[lat - c_LAT]++;
        end
        for (int k = 0; k < 4; k++) begin
            check("stall_hist", 32'(hist[k] != 0), 32'd1);
        end
`else
        for (int k = 0; k < 4; k++) hist[k] = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
